register_file_scoreboard: RTL and testbench
===========================================

// Module: register_file_scoreboard
// PURPOSE
//  Parametrised multi-read-port register file for the pipelined RISC-V core.
//  Provides a synchronous clear, optional write-to-read bypass and a per-register busy scoreboard.
//  The issue stage reserves a destination register, and writeback clears the reservation.
//  Sits between decode (read/reserve) and writeback (write); x0 is hardwired to zero when ZERO_REG=1.
// PARAMETERS
//  W        32  data width of each register
//  AW       5   address width; depth is 2**AW registers
//  NR       2   number of independent read ports (1..4)
//  ZERO_REG 1   1: register 0 reads 0, ignores writes and is never busy
//  BYPASS   1   1: a same-cycle write is forwarded to matching read ports
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high; clears all registers and busy bits
//  wr_ena    in   1      write enable (writeback)
//  wr_addr   in   AW     write address
//  wr_data   in   W      write data
//  rsv_ena   in   1      reserve enable (issue); marks rsv_addr busy
//  rsv_addr  in   AW     register to reserve
//  rd_addr   in   NR*AW  read addresses; port i uses [i*AW +: AW]
//  rd_data   out  NR*W   read data; port i uses [i*W +: W]
//  rd_busy   out  NR     1 = port i register has an outstanding reservation
// BEHAVIOUR
//  Storage: 2**AW x W flops, each with its own enable.
//   - Built from explicit registers with enables, not an inferred RAM array.
//   - Read ports are combinational muxes on rd_addr.
//  Reset: on a clk edge with rst=1, every register becomes 0 and every busy bit becomes 0.
//   - rst overrides wr_ena and rsv_ena in the same cycle.
//   - After reset, rd_data is 0 and rd_busy is 0 for all ports, for any address.
//  Write: at a clk edge with wr_ena=1 and rst=0, reg[wr_addr] <= wr_data.
//   - With ZERO_REG=1, wr_addr==0 is a no-op.
//  Read latency:
//   - BYPASS=0: rd_data shows the value stored at the last edge (0 cycles after the edge).
//   - BYPASS=1: if wr_ena=1, wr_addr==rd_addr[i] and the address is not a hardwired zero,
//     rd_data[i] = wr_data in the same cycle.
//  Scoreboard, per register, evaluated at each clk edge with rst=0:
//   - busy <= 1 if rsv_ena and rsv_addr==r.
//   - Else busy <= 0 if wr_ena and wr_addr==r.
//   - Else busy holds.
//   - Reserve and write to the same r in the same cycle: reserve wins and busy stays 1
//     (a new producer has been issued).
//   - ZERO_REG=1: busy[0] is constant 0; reserving address 0 is ignored.
//  rd_busy[i] = busy[rd_addr[i]].
//   - With BYPASS=1, rd_busy[i] is forced 0 when a same-cycle write matches rd_addr[i],
//     because the data is being forwarded.
//   - rd_busy does not reflect a same-cycle reserve; it takes effect after the edge.
//  Multiple read ports may address the same register; each receives identical data and busy.
//  No internal state other than the registers and busy bits; no illegal states are reachable.
// TESTING
//  1. Reset: write 0xDEADBEEF to x5, then pulse rst for 1 cycle.
//     -> reading x5 gives 0x00000000 and rd_busy=0 on all ports.
//  2. x0: write 0xFFFFFFFF to addr 0 and reserve addr 0.
//     -> rd_data=0 and rd_busy=0 on every port.
//  3. Reserve/write: reserve x7, then next cycle read x7 -> rd_busy=1.
//     Write 0x12345678 to x7 -> with BYPASS=1, same cycle gives rd_data=0x12345678 and rd_busy=0.
//     After the edge, busy stays 0.
//  4. Collision: with x9 busy, assert rsv_ena and wr_ena to x9 together with data 0xA5A5A5A5.
//     -> after the edge, x9 reads 0xA5A5A5A5 and rd_busy=1.
//  5. BYPASS=0 build: write 0x55 to x3 while reading x3.
//     -> same cycle shows the old value; the next cycle shows 0x55.
//  6. Multi-port with NR=3: ports read x1, x2, x1 after writes 0x11 to x1 and 0x22 to x2.
//     -> rd_data = {0x11, 0x22, 0x11}.
//     Also sweep all 2**AW addresses: write-then-read of each returns the address value.

Source files
------------

// File: rtl/register_file_scoreboard_if.sv
// register_file_scoreboard_if
//   Bundles the write, reserve and read signals of the register file.
//   Port summary:
//     wr_ena / wr_addr / wr_data   writeback write port
//     rsv_ena / rsv_addr           issue-stage reservation of a destination
//     rd_addr                      NR packed read addresses, port i at [i*AW +: AW]
//     rd_data                      NR packed read values, port i at [i*W +: W]
//     rd_busy                      NR busy flags, one per read port
//   Modports: master drives requests (decode/writeback side), slave is the
//   register file itself.
interface register_file_scoreboard_if #(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic               wr_ena;
    logic [AW-1:0]      wr_addr;
    logic [W-1:0]       wr_data;
    logic               rsv_ena;
    logic [AW-1:0]      rsv_addr;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*W-1:0]    rd_data;
    logic [NR-1:0]      rd_busy;

    modport master (
        output wr_ena, wr_addr, wr_data,
        output rsv_ena, rsv_addr,
        output rd_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data,
        input  rsv_ena, rsv_addr,
        input  rd_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Multi-read-port register file with a per-register busy scoreboard for the
//   pipelined RISC-V core. Issue reserves a destination (busy=1), writeback
//   stores the result and clears the reservation. Optional same-cycle
//   write-to-read forwarding and a hardwired-zero register 0.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high clear of all registers and busy bits
//     bus   register_file_scoreboard_if.slave (write, reserve and read ports)
//   Parameters: W data width, AW address width (2**AW registers), NR read
//   ports, ZERO_REG hardwires register 0, BYPASS enables forwarding.
module register_file_scoreboard #(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    register_file_scoreboard_if.slave    bus
);
    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] reg_q  [DEPTH];
    logic         busy_q [DEPTH];

    // Each register is its own enabled flop group so the storage maps to
    // plain flops rather than a RAM macro.
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign reg_q[r]  = '0;
            assign busy_q[r] = 1'b0;
        end else begin : g_live
            logic [W-1:0] data_q;
            logic         busy_bit_q;
            logic         wr_hit;
            logic         rsv_hit;

            assign wr_hit  = bus.wr_ena  && (bus.wr_addr  == AW'(r));
            assign rsv_hit = bus.rsv_ena && (bus.rsv_addr == AW'(r));

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q <= '0;
                end else if (wr_hit) begin
                    data_q <= bus.wr_data;
                end
            end

            // A reserve in the same cycle as the write means a newer producer
            // has been issued, so the reservation must win.
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_bit_q <= 1'b0;
                end else if (rsv_hit) begin
                    busy_bit_q <= 1'b1;
                end else if (wr_hit) begin
                    busy_bit_q <= 1'b0;
                end
            end

            assign reg_q[r]  = data_q;
            assign busy_q[r] = busy_bit_q;
        end
    end

    // Combinational read muxes. A forwarded write also hides the busy flag,
    // since the consumer is receiving the value it was waiting for.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = bus.rd_addr[i*AW +: AW];
        assign hit  = (BYPASS != 0) && bus.wr_ena && (bus.wr_addr == addr)
                      && !((ZERO_REG != 0) && (addr == '0));

        assign bus.rd_data[i*W +: W] = hit ? bus.wr_data : reg_q[addr];
        assign bus.rd_busy[i]        = hit ? 1'b0 : busy_q[addr];
    end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb_register_file_scoreboard
//   Drives two register files from one write/reserve stream: dut_a has three
//   read ports with forwarding, dut_b has two read ports without forwarding.
//   A behavioural model (plain arrays of values and busy flags) predicts every
//   read port on every cycle; directed scenarios add literal expectations.
module tb_register_file_scoreboard;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int NRA   = 3;
    localparam int NRB   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               wr_ena;
    logic [AW-1:0]      wr_addr;
    logic [W-1:0]       wr_data;
    logic               rsv_ena;
    logic [AW-1:0]      rsv_addr;
    logic [NRA*AW-1:0]  rd_addr_a;
    logic [NRB*AW-1:0]  rd_addr_b;

    int  checks = 0;
    int  errors = 0;
    bit  check_en = 1'b0;

    register_file_scoreboard_if #(.W(W), .AW(AW), .NR(NRA)) if_a ();
    register_file_scoreboard_if #(.W(W), .AW(AW), .NR(NRB)) if_b ();

    assign if_a.wr_ena   = wr_ena;
    assign if_a.wr_addr  = wr_addr;
    assign if_a.wr_data  = wr_data;
    assign if_a.rsv_ena  = rsv_ena;
    assign if_a.rsv_addr = rsv_addr;
    assign if_a.rd_addr  = rd_addr_a;
    assign if_b.wr_ena   = wr_ena;
    assign if_b.wr_addr  = wr_addr;
    assign if_b.wr_data  = wr_data;
    assign if_b.rsv_ena  = rsv_ena;
    assign if_b.rsv_addr = rsv_addr;
    assign if_b.rd_addr  = rd_addr_b;

    register_file_scoreboard #(.W(W), .AW(AW), .NR(NRA), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    register_file_scoreboard #(.W(W), .AW(AW), .NR(NRB), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // Behavioural model: architectural register values and outstanding
    // reservations, updated by the rules at each rising edge.
    logic [W-1:0] m_mem  [DEPTH];
    bit           m_busy [DEPTH];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            if (wr_ena && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_ena && rsv_addr != 0) begin
                m_busy[rsv_addr] = 1'b1;
            end
        end
    end

    function automatic logic [W-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (byp && wr_ena && wr_addr == a && a != 0) return wr_data;
        if (a == 0) return '0;
        return m_mem[a];
    endfunction

    function automatic logic [W-1:0] exp_busy(input logic [AW-1:0] a, input bit byp);
        if (byp && wr_ena && wr_addr == a && a != 0) return '0;
        if (a == 0) return '0;
        return W'(m_busy[a]);
    endfunction

    task automatic check_output(input string name, input int port,
                                input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s port %0d at %0t: got %h expected %h", name, port, $time, act, expv);
        end
    endtask

    // Model-versus-DUT comparison on every falling edge while checking is on.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NRA; i++) begin
                logic [AW-1:0] a;
                a = rd_addr_a[i*AW +: AW];
                check_output("model_a_data", i, if_a.rd_data[i*W +: W], exp_data(a, 1'b1));
                check_output("model_a_busy", i, W'(if_a.rd_busy[i]), exp_busy(a, 1'b1));
            end
            for (int i = 0; i < NRB; i++) begin
                logic [AW-1:0] a;
                a = rd_addr_b[i*AW +: AW];
                check_output("model_b_data", i, if_b.rd_data[i*W +: W], exp_data(a, 1'b0));
                check_output("model_b_busy", i, W'(if_b.rd_busy[i]), exp_busy(a, 1'b0));
            end
        end
    end

    task automatic apply_stimulus(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                                  input logic re, input logic [AW-1:0] ra);
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_ena  = re;
        rsv_addr = ra;
    endtask

    task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic [AW-1:0] b0, input logic [AW-1:0] b1);
        rd_addr_a = {a2, a1, a0};
        rd_addr_b = {b1, b0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < NRA; i++) begin
            check_output({name, "_a_data"}, i, if_a.rd_data[i*W +: W], 32'h0);
            check_output({name, "_a_busy"}, i, W'(if_a.rd_busy[i]), 32'h0);
        end
        for (int i = 0; i < NRB; i++) begin
            check_output({name, "_b_data"}, i, if_b.rd_data[i*W +: W], 32'h0);
            check_output({name, "_b_busy"}, i, W'(if_b.rd_busy[i]), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_reads(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        check_en = 1'b1;

        // Power-on reset leaves every port reading zero and not busy.
        set_reads(5, 17, 31, 5, 31);
        settle();
        check_all_zero("por");

        // Reset clears a written and reserved register.
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5);
        tick();
        idle();
        set_reads(5, 5, 5, 5, 5);
        settle();
        check_output("x5_written", 0, if_a.rd_data[31:0], 32'hDEADBEEF);
        check_output("x5_busy", 0, W'(if_a.rd_busy[0]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_all_zero("reset_x5");

        // Register 0 ignores writes and reservations, and is never forwarded.
        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        set_reads(0, 0, 0, 0, 0);
        settle();
        check_all_zero("x0_same");
        tick();
        idle();
        settle();
        check_all_zero("x0_after");

        // Reserve then write x7: busy, then forwarded and released.
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd7);
        set_reads(7, 7, 7, 7, 7);
        tick();
        idle();
        settle();
        check_output("x7_rsv_busy_a", 0, W'(if_a.rd_busy[0]), 32'h1);
        check_output("x7_rsv_busy_b", 0, W'(if_b.rd_busy[0]), 32'h1);
        apply_stimulus(1'b1, 5'd7, 32'h12345678, 1'b0, '0);
        settle();
        check_output("x7_fwd_data_a", 2, if_a.rd_data[95:64], 32'h12345678);
        check_output("x7_fwd_busy_a", 2, W'(if_a.rd_busy[2]), 32'h0);
        check_output("x7_nofwd_data_b", 0, if_b.rd_data[31:0], 32'h0);
        check_output("x7_nofwd_busy_b", 0, W'(if_b.rd_busy[0]), 32'h1);
        tick();
        idle();
        settle();
        check_output("x7_after_busy_a", 0, W'(if_a.rd_busy[0]), 32'h0);
        check_output("x7_after_data_b", 1, if_b.rd_data[63:32], 32'h12345678);

        // Reserve and write collide on busy x9: the reservation survives.
        apply_stimulus(1'b0, '0, '0, 1'b1, 5'd9);
        tick();
        apply_stimulus(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9);
        set_reads(9, 9, 9, 9, 9);
        tick();
        idle();
        settle();
        check_output("x9_data_a", 1, if_a.rd_data[63:32], 32'hA5A5A5A5);
        check_output("x9_busy_a", 1, W'(if_a.rd_busy[1]), 32'h1);
        check_output("x9_busy_b", 0, W'(if_b.rd_busy[0]), 32'h1);

        // Without forwarding the write to x3 appears only after the edge.
        apply_stimulus(1'b1, 5'd3, 32'h55, 1'b0, '0);
        set_reads(3, 3, 3, 3, 3);
        settle();
        check_output("x3_old_b", 0, if_b.rd_data[31:0], 32'h0);
        check_output("x3_fwd_a", 0, if_a.rd_data[31:0], 32'h55);
        tick();
        idle();
        settle();
        check_output("x3_new_b", 0, if_b.rd_data[31:0], 32'h55);

        // Three ports reading x1, x2, x1.
        apply_stimulus(1'b1, 5'd1, 32'h11, 1'b0, '0);
        tick();
        apply_stimulus(1'b1, 5'd2, 32'h22, 1'b0, '0);
        tick();
        idle();
        set_reads(1, 2, 1, 2, 1);
        settle();
        check_output("multi_p0", 0, if_a.rd_data[31:0],  32'h11);
        check_output("multi_p1", 1, if_a.rd_data[63:32], 32'h22);
        check_output("multi_p2", 2, if_a.rd_data[95:64], 32'h11);

        // Address sweep: each register holds its own address after a write.
        for (int a = 0; a < DEPTH; a++) begin
            apply_stimulus(1'b1, AW'(a), W'(a), 1'b0, '0);
            tick();
            idle();
            set_reads(AW'(a), AW'(a), AW'(a), AW'(a), AW'(a));
            settle();
            check_output("sweep_b", a, if_b.rd_data[31:0], W'(a));
            tick();
        end

        // Random traffic, rd addresses often aimed at the write address.
        repeat (600) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra [5];
            rst = ($urandom_range(0, 49) == 0);
            wa = AW'($urandom_range(0, DEPTH - 1));
            apply_stimulus($urandom_range(0, 1) == 1, wa, $urandom,
                           $urandom_range(0, 2) == 0, AW'($urandom_range(0, DEPTH - 1)));
            for (int p = 0; p < 5; p++) begin
                ra[p] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            end
            set_reads(ra[0], ra[1], ra[2], ra[3], ra[4]);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        check_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
